// File: rtl/split_pkg.sv
// Shared definitions for the split constraint checker family.
//   split_mode_e    : run-time constraint selector (TRUE, SUM_LE, SUM_EQ, MAX_LE)
//   split_state_e   : frame FSM states (IDLE, ACCUM, DONE)
//   split_sum_width : width of a sum of num_vars values of var_w bits that
//                     can never overflow
package split_pkg;

    typedef enum logic [1:0] {
        SPLIT_TRUE   = 2'd0,
        SPLIT_SUM_LE = 2'd1,
        SPLIT_SUM_EQ = 2'd2,
        SPLIT_MAX_LE = 2'd3
    } split_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } split_state_e;

    function automatic int split_sum_width(input int num_vars, input int var_w);
        return var_w + $clog2(num_vars);
    endfunction

endpackage

// File: rtl/split_cmp.sv
// Combinational constraint evaluation shared by split checker variants.
// Ports:
//   mode_i  : constraint mode
//   sum_i   : accumulated sum of the frame
//   max_i   : largest value of the frame
//   bound_i : bound for the SUM_LE / SUM_EQ / MAX_LE modes
//   sat_o   : constraint satisfied (all comparisons unsigned)
module split_cmp
    import split_pkg::*;
#(
    parameter int VAR_W = 16,
    parameter int SUM_W = 24
) (
    input  split_mode_e      mode_i,
    input  logic [SUM_W-1:0] sum_i,
    input  logic [VAR_W-1:0] max_i,
    input  logic [SUM_W-1:0] bound_i,
    output logic             sat_o
);

    always_comb begin
        sat_o = 1'b1;
        case (mode_i)
            SPLIT_TRUE:   sat_o = 1'b1;
            SPLIT_SUM_LE: sat_o = (sum_i <= bound_i);
            SPLIT_SUM_EQ: sat_o = (sum_i == bound_i);
            // Max is zero-extended so the bound keeps its full range.
            SPLIT_MAX_LE: sat_o = (SUM_W'(max_i) <= bound_i);
            default:      sat_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/split_stream_checker.sv
// Serial frame constraint checker. Accepts NUM_VARS values per frame over a
// valid/ready stream, accumulates sum and max, evaluates the constraint
// selected at the first beat and holds one result per frame.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never drops, and its payload never changes, until that
// transfer. Ready may depend on state but never on the matching valid.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   cfg_mode, cfg_bound    : constraint config, sampled on the first beat
//   in_valid/in_ready      : input beat handshake; in_data value, in_last end
//   res_valid/res_ready    : result handshake
//   res_sat, res_sum,
//   res_max, err_len       : registered result of the last completed frame
//   dbg_state              : current FSM state (split_state_e encoding)
module split_stream_checker
    import split_pkg::*;
#(
    parameter int NUM_VARS = 150,
    parameter int VAR_W    = 16,
    parameter int CNT_W    = $clog2(NUM_VARS + 1),
    parameter int SUM_W    = split_sum_width(NUM_VARS, VAR_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [SUM_W-1:0] cfg_bound,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAR_W-1:0] in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_sat,
    output logic [SUM_W-1:0] res_sum,
    output logic [VAR_W-1:0] res_max,
    output logic             err_len,
    output logic [1:0]       dbg_state
);

    split_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [VAR_W-1:0] max_q, max_d;
    split_mode_e      mode_q, mode_d;
    logic [SUM_W-1:0] bound_q, bound_d;
    logic             r_sat_q, r_sat_d;
    logic [SUM_W-1:0] r_sum_q, r_sum_d;
    logic [VAR_W-1:0] r_max_q, r_max_d;
    logic             r_err_q, r_err_d;

    logic             beat_ok;
    logic             first_beat;
    split_mode_e      eff_mode;
    logic [SUM_W-1:0] eff_bound;
    logic [SUM_W-1:0] base_sum, beat_sum;
    logic [VAR_W-1:0] base_max, beat_max;
    logic [CNT_W-1:0] base_cnt, beat_cnt;
    logic             hit_len, frame_end, frame_err;
    logic             cmp_sat;

    assign in_ready  = (state_q != ST_DONE) && !rst;
    assign beat_ok   = in_valid && in_ready;
    assign res_valid = (state_q == ST_DONE);
    assign res_sat   = r_sat_q;
    assign res_sum   = r_sum_q;
    assign res_max   = r_max_q;
    assign err_len   = r_err_q;
    assign dbg_state = state_q;

    // The first beat starts from an empty accumulator and the live config;
    // later beats use the running values and the config latched at beat 1.
    assign first_beat = (state_q == ST_IDLE);
    assign eff_mode   = first_beat ? split_mode_e'(cfg_mode) : mode_q;
    assign eff_bound  = first_beat ? cfg_bound : bound_q;
    assign base_sum   = first_beat ? '0 : sum_q;
    assign base_max   = first_beat ? '0 : max_q;
    assign base_cnt   = first_beat ? '0 : cnt_q;

    assign beat_sum  = base_sum + SUM_W'(in_data);
    assign beat_max  = (in_data > base_max) ? in_data : base_max;
    assign beat_cnt  = base_cnt + CNT_W'(1);
    assign hit_len   = (beat_cnt == CNT_W'(NUM_VARS));
    // A full frame without in_last still closes, but is flagged.
    assign frame_end = in_last || hit_len;
    assign frame_err = !(in_last && hit_len);

    split_cmp #(
        .VAR_W (VAR_W),
        .SUM_W (SUM_W)
    ) u_cmp (
        .mode_i  (eff_mode),
        .sum_i   (beat_sum),
        .max_i   (beat_max),
        .bound_i (eff_bound),
        .sat_o   (cmp_sat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        max_d   = max_q;
        mode_d  = mode_q;
        bound_d = bound_q;
        r_sat_d = r_sat_q;
        r_sum_d = r_sum_q;
        r_max_d = r_max_q;
        r_err_d = r_err_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (beat_ok) begin
                    mode_d  = eff_mode;
                    bound_d = eff_bound;
                    sum_d   = beat_sum;
                    max_d   = beat_max;
                    cnt_d   = beat_cnt;
                    if (frame_end) begin
                        state_d = ST_DONE;
                        r_sum_d = beat_sum;
                        r_max_d = beat_max;
                        r_err_d = frame_err;
                        r_sat_d = cmp_sat && !frame_err;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            mode_q  <= SPLIT_TRUE;
            bound_q <= '0;
            r_sat_q <= 1'b0;
            r_sum_q <= '0;
            r_max_q <= '0;
            r_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            mode_q  <= mode_d;
            bound_q <= bound_d;
            r_sat_q <= r_sat_d;
            r_sum_q <= r_sum_d;
            r_max_q <= r_max_d;
            r_err_q <= r_err_d;
        end
    end

endmodule

// File: tb/tb_split_stream_checker.sv
module tb_split_stream_checker;
    import split_pkg::*;

    localparam int NV = 4;
    localparam int VW = 8;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_mode;
    logic [SW-1:0] cfg_bound;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          in_last;
    logic          res_valid;
    logic          res_ready;
    logic          res_sat;
    logic [SW-1:0] res_sum;
    logic [VW-1:0] res_max;
    logic          err_len;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // {err, sat, sum, max}
    logic [SW+VW+1:0] exp_q[$];

    typedef struct {
        logic [1:0]    mode;
        logic [SW-1:0] bound;
        int            len;
        logic [VW-1:0] d[NV];
        logic          e_sat;
        logic [SW-1:0] e_sum;
        logic [VW-1:0] e_max;
        logic          e_err;
    } vec_t;

    vec_t tbl[11];

    split_stream_checker #(
        .NUM_VARS (NV),
        .VAR_W    (VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_bound (cfg_bound),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sat   (res_sat),
        .res_sum   (res_sum),
        .res_max   (res_max),
        .err_len   (err_len),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [VW-1:0] d, input logic last,
                             input logic [1:0] mode, input logic [SW-1:0] bound);
        int budget;
        budget = 0;
        cfg_mode  = mode;
        cfg_bound = bound;
        in_data   = d;
        in_last   = last;
        in_valid  = 1'b1;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        chk("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input int hold, input logic e_err,
                              input logic e_sat, input logic [SW-1:0] e_sum,
                              input logic [VW-1:0] e_max);
        int budget;
        budget = 0;
        while (!res_valid && budget < 50) begin
            tick();
            budget++;
        end
        chk({name, "_valid"}, res_valid, 1);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({name, "_held"}, res_valid, 1);
        end
        chk({name, "_sat"}, res_sat, e_sat);
        chk({name, "_sum"}, res_sum, e_sum);
        chk({name, "_max"}, res_max, e_max);
        chk({name, "_err"}, err_len, e_err);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, "_valid_drop"}, res_valid, 0);
        chk({name, "_ready_back"}, in_ready, 1);
    endtask

    task automatic set_vec(input int i, input logic [1:0] mode, input logic [SW-1:0] bound,
                           input int len, input int d0, input int d1, input int d2, input int d3,
                           input logic s, input int sum, input int mx, input logic e);
        tbl[i].mode  = mode;
        tbl[i].bound = bound;
        tbl[i].len   = len;
        tbl[i].d[0]  = VW'(d0);
        tbl[i].d[1]  = VW'(d1);
        tbl[i].d[2]  = VW'(d2);
        tbl[i].d[3]  = VW'(d3);
        tbl[i].e_sat = s;
        tbl[i].e_sum = SW'(sum);
        tbl[i].e_max = VW'(mx);
        tbl[i].e_err = e;
    endtask

    // Reference model: frame result from the rules, with plain integers.
    function automatic logic ref_sat(input int mode, input int sum, input int mx,
                                     input int bound, input logic err);
        if (err) return 1'b0;
        case (mode)
            0: return 1'b1;
            1: return sum <= bound;
            2: return sum == bound;
            default: return mx <= bound;
        endcase
    endfunction

    // ---------------- test ----------------
    initial begin
        int m_len, m_sum, m_max, m_mode, m_bound, n_beats;
        logic [VW-1:0] d;
        logic last, err, sat;
        logic [1:0] mode;
        logic [SW-1:0] bound;
        logic [SW+VW+1:0] e;

        rst = 1'b1;
        cfg_mode = 2'd0; cfg_bound = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;

        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sat", res_sat, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_max", res_max, 0);
        chk("rst_err_len", err_len, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // mode, bound, len, data, sat, sum, max, err
        set_vec(0,  SPLIT_TRUE,   0,    4, 5, 10, 15, 20,   1, 50, 20, 0);
        set_vec(1,  SPLIT_SUM_LE, 50,   4, 5, 10, 15, 20,   1, 50, 20, 0);
        set_vec(2,  SPLIT_SUM_LE, 49,   4, 5, 10, 15, 20,   0, 50, 20, 0);
        set_vec(3,  SPLIT_SUM_EQ, 50,   4, 5, 10, 15, 20,   1, 50, 20, 0);
        set_vec(4,  SPLIT_SUM_EQ, 49,   4, 5, 10, 15, 20,   0, 50, 20, 0);
        set_vec(5,  SPLIT_MAX_LE, 254,  4, 255, 0, 0, 0,    0, 255, 255, 0);
        set_vec(6,  SPLIT_MAX_LE, 255,  4, 255, 0, 0, 0,    1, 255, 255, 0);
        set_vec(7,  SPLIT_TRUE,   0,    4, 255, 255, 255, 255, 1, 1020, 255, 0);
        set_vec(8,  SPLIT_TRUE,   0,    2, 3, 9, 0, 0,      0, 12, 9, 1);
        set_vec(9,  SPLIT_SUM_LE, 1000, 1, 7, 0, 0, 0,      0, 7, 7, 1);
        set_vec(10, SPLIT_MAX_LE, 20,   4, 20, 3, 20, 1,    1, 44, 20, 0);

        for (int i = 0; i < 11; i++) begin
            for (int b = 0; b < tbl[i].len; b++) begin
                send_beat(tbl[i].d[b], b == tbl[i].len - 1, tbl[i].mode, tbl[i].bound);
                if (b < tbl[i].len - 1) chk($sformatf("vec%0d_early_valid", i), res_valid, 0);
            end
            chk($sformatf("vec%0d_latency", i), res_valid, 1);
            get_result($sformatf("vec%0d", i), 0, tbl[i].e_err, tbl[i].e_sat,
                       tbl[i].e_sum, tbl[i].e_max);
        end

        // Full frame without in_last closes with err; next beats form a new frame.
        send_beat(8'd1, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd2, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd3, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd4, 1'b0, SPLIT_TRUE, 0);
        chk("nolast_latency", res_valid, 1);
        get_result("nolast", 0, 1'b1, 1'b0, 10'd10, 8'd4);
        for (int b = 0; b < NV; b++) send_beat(8'd2, b == NV - 1, SPLIT_TRUE, 0);
        get_result("after_nolast", 0, 1'b0, 1'b1, 10'd8, 8'd2);

        // Backpressure: result held, input blocked, stray beats ignored.
        send_beat(8'd5, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd10, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd15, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd20, 1'b1, SPLIT_TRUE, 0);
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid", res_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", res_sum, 50);
            chk("bp_max", res_max, 20);
            chk("bp_sat", res_sat, 1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        get_result("bp", 0, 1'b0, 1'b1, 10'd50, 8'd20);

        // Config changed mid-frame: the beat-1 mode (SUM_EQ 50) must apply.
        send_beat(8'd5, 1'b0, SPLIT_SUM_EQ, 10'd50);
        send_beat(8'd10, 1'b0, SPLIT_SUM_LE, 10'd0);
        send_beat(8'd15, 1'b0, SPLIT_MAX_LE, 10'd0);
        send_beat(8'd20, 1'b1, SPLIT_SUM_LE, 10'd0);
        get_result("cfg_latch", 0, 1'b0, 1'b1, 10'd50, 8'd20);

        // Reset after two beats discards the frame.
        send_beat(8'd1, 1'b0, SPLIT_TRUE, 0);
        send_beat(8'd2, 1'b0, SPLIT_TRUE, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_sum", res_sum, 0);
        chk("mid_rst_max", res_max, 0);
        chk("mid_rst_sat", res_sat, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_back", in_ready, 1);
        chk("mid_rst_no_result", res_valid, 0);
        for (int b = 0; b < NV; b++) begin
            send_beat(8'd1, b == NV - 1, SPLIT_TRUE, 0);
            if (b < NV - 1) chk("after_rst_early_valid", res_valid, 0);
        end
        get_result("after_rst", 0, 1'b0, 1'b1, 10'd4, 8'd1);

        // Randomized stream against the reference model.
        m_len = 0; m_sum = 0; m_max = 0; m_mode = 0; m_bound = 0; n_beats = 0;
        while (n_beats < 200 || m_len != 0) begin
            d     = VW'($urandom_range(0, 255));
            mode  = 2'($urandom_range(0, 3));
            bound = SW'($urandom_range(0, 700));
            if (n_beats >= 200) last = 1'b1;
            else if (m_len == NV - 1) last = ($urandom_range(0, 3) != 0);
            else last = ($urandom_range(0, 5) == 0);
            if (m_len == 0) begin
                m_mode = int'(mode); m_bound = int'(bound); m_sum = 0; m_max = 0;
            end
            m_len++;
            m_sum += int'(d);
            if (int'(d) > m_max) m_max = int'(d);
            repeat ($urandom_range(0, 2)) tick();
            send_beat(d, last, mode, bound);
            n_beats++;
            if (last || m_len == NV) begin
                err = !(last && m_len == NV);
                sat = ref_sat(m_mode, m_sum, m_max, m_bound, err);
                exp_q.push_back({err, sat, SW'(m_sum), VW'(m_max)});
                m_len = 0;
                e = exp_q.pop_front();
                get_result("rand", $urandom_range(0, 3), e[SW+VW+1], e[SW+VW],
                           e[SW+VW-1:VW], e[VW-1:0]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
